// File: rtl/t01_ai_layer_seq.sv
// t01_ai_layer_seq: sequences a 4-layer network through an external MMU.
// Loads four signed input features into activation bank B0, then for each
// layer pulses mmu_start, streams the read bank to the MMU and collects the
// requantised (>> SHIFT, clipped to 127) results into the other bank. The
// single layer-3 result is returned on result_out with a result_valid pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_data/in_ready input feature handshake (8-bit signed)
//   mmu_start                 one-cycle start pulse per layer
//   mmu_layer_sel             current layer index
//   mmu_act_valid/mmu_act_in  activation stream to the MMU
//   mmu_res_valid/mmu_res_out result stream from the MMU (18-bit, ReLU'd)
//   mmu_done                  last MMU result of the current layer
//   result_valid/result_out   final network output
//   busy                      high whenever not idle
module t01_ai_layer_seq #(
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mmu_start,
  output logic [1:0]  mmu_layer_sel,
  output logic        mmu_act_valid,
  output logic [7:0]  mmu_act_in,
  input  logic        mmu_res_valid,
  input  logic [17:0] mmu_res_out,
  input  logic        mmu_done,
  output logic        result_valid,
  output logic [17:0] result_out,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, START, STREAM, COLLECT, FINISH} state_t;

  state_t      state;
  logic [1:0]  layer;
  logic [1:0]  ld_idx;
  logic [5:0]  sidx;
  logic [5:0]  cidx;
  logic [5:0]  n_act;
  logic [7:0]  b0 [32];
  logic [7:0]  b1 [32];
  logic [17:0] shifted;
  logic [7:0]  q;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_act;
  logic        load_fire;
  logic        col_fire;
  logic        b0_we;
  logic        b1_we;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;

  assign mmu_layer_sel = layer;

  always_comb begin
    shifted   = mmu_res_out >> SHIFT;
    q         = (shifted > 18'd127) ? 8'd127 : shifted[7:0];
    n_act     = (layer == 2'd0) ? 6'd4 : 6'd32;
    // START presents entry 0 itself so the stream leaves START already valid
    rd_addr   = (state == START) ? 5'd0 : sidx[4:0];
    rd_act    = layer[0] ? b1[rd_addr] : b0[rd_addr];
    load_fire = in_valid && in_ready && (state == IDLE || state == LOAD);
    // cidx saturates at 32; bit 5 set means the bank is full and writes drop
    col_fire  = (state == COLLECT) && (layer != 2'd3) && mmu_res_valid && !cidx[5];
    b0_we     = !rst && (load_fire || (col_fire && layer[0]));
    b1_we     = !rst && col_fire && !layer[0];
    wr_addr   = load_fire ? ((state == IDLE) ? 5'd0 : {3'b000, ld_idx}) : cidx[4:0];
    wr_data   = load_fire ? in_data : q;
  end

  // Banks are deliberately not reset; contents persist across runs.
  always_ff @(posedge clk) begin
    if (b0_we) b0[wr_addr] <= wr_data;
    if (b1_we) b1[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      layer         <= '0;
      ld_idx        <= '0;
      sidx          <= '0;
      cidx          <= '0;
      in_ready      <= 1'b0;
      mmu_start     <= 1'b0;
      mmu_act_valid <= 1'b0;
      mmu_act_in    <= '0;
      result_valid  <= 1'b0;
      result_out    <= '0;
      busy          <= 1'b0;
    end else begin
      mmu_start    <= 1'b0;
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (load_fire) begin
            ld_idx <= 2'd1;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (load_fire) begin
            if (ld_idx == 2'd3) begin
              layer     <= '0;
              in_ready  <= 1'b0;
              mmu_start <= 1'b1;
              state     <= START;
            end else begin
              ld_idx <= ld_idx + 2'd1;
            end
          end
        end
        START: begin
          // entry 0 goes out on this edge, so the index restarts at 1
          sidx          <= 6'd1;
          mmu_act_valid <= 1'b1;
          mmu_act_in    <= rd_act;
          state         <= STREAM;
        end
        STREAM: begin
          if (sidx == n_act) begin
            mmu_act_valid <= 1'b0;
            mmu_act_in    <= '0;
            cidx          <= '0;
            state         <= COLLECT;
          end else begin
            mmu_act_in <= rd_act;
            sidx       <= sidx + 6'd1;
          end
        end
        COLLECT: begin
          if (layer != 2'd3) begin
            if (col_fire) cidx <= cidx + 6'd1;
            if (mmu_done) begin
              layer     <= layer + 2'd1;
              mmu_start <= 1'b1;
              state     <= START;
            end
          end else if (mmu_res_valid) begin
            result_out <= mmu_res_out;
            state      <= FINISH;
          end
        end
        FINISH: begin
          result_valid <= 1'b1;
          busy         <= 1'b0;
          in_ready     <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t01_ai_layer_seq.sv
module tb_t01_ai_layer_seq;
  localparam int SHIFT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mmu_start;
  logic [1:0]  mmu_layer_sel;
  logic        mmu_act_valid;
  logic [7:0]  mmu_act_in;
  logic        mmu_res_valid;
  logic [17:0] mmu_res_out;
  logic        mmu_done;
  logic        result_valid;
  logic [17:0] result_out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // reference activation banks and stimulus state
  logic [7:0] m0 [32];
  logic [7:0] m1 [32];
  logic [7:0] feat [4];
  int         fixed_q [$];
  int         l3_val;

  t01_ai_layer_seq #(.SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mmu_start(mmu_start), .mmu_layer_sel(mmu_layer_sel),
    .mmu_act_valid(mmu_act_valid), .mmu_act_in(mmu_act_in),
    .mmu_res_valid(mmu_res_valid), .mmu_res_out(mmu_res_out),
    .mmu_done(mmu_done), .result_valid(result_valid),
    .result_out(result_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rq(input int r);
    int s;
    s = r >> SHIFT;
    return (s > 127) ? 8'd127 : 8'(s);
  endfunction

  task automatic load4(input bit gapped);
    int budget;
    for (int i = 0; i < 4; i++) begin
      budget = 0;
      while (in_ready !== 1'b1 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = feat[i];
      m0[i]    = feat[i];
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
      if (gapped && i < 3) @(negedge clk);
    end
  endtask

  task automatic run_layer(input int lay, input int nres, input bit done_sep,
                           input bit stray_in, input int abort_after);
    int budget;
    int cnt;
    int r;
    budget = 0;
    while (mmu_start !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("start_seen", {31'd0, mmu_start}, 32'd1);
    chk("layer_sel", {30'd0, mmu_layer_sel}, lay);
    chk("busy_run", {31'd0, busy}, 32'd1);
    chk("in_ready_run", {31'd0, in_ready}, 32'd0);
    if (stray_in) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
    end
    @(negedge clk);
    chk("start_one_cycle", {31'd0, mmu_start}, 32'd0);
    cnt = 0;
    while (mmu_act_valid === 1'b1 && cnt < 40) begin
      chk("act_value", {24'd0, mmu_act_in}, {24'd0, (lay % 2 == 0) ? m0[cnt % 32] : m1[cnt % 32]});
      cnt++;
      if (cnt == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_start", {31'd0, mmu_start}, 32'd0);
        chk("abort_act_valid", {31'd0, mmu_act_valid}, 32'd0);
        chk("abort_act_in", {24'd0, mmu_act_in}, 32'd0);
        chk("abort_result_valid", {31'd0, result_valid}, 32'd0);
        chk("abort_result_out", {14'd0, result_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_layer_sel", {30'd0, mmu_layer_sel}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("act_count", cnt, (lay == 0) ? 4 : 32);
    chk("act_in_idle_zero", {24'd0, mmu_act_in}, 32'd0);
    if (lay < 3) begin
      for (int i = 0; i < nres; i++) begin
        r = (fixed_q.size() > 0) ? fixed_q.pop_front() : int'($urandom_range(0, 2500));
        if ($urandom_range(0, 4) == 0) begin
          mmu_res_valid = 1'b0;
          mmu_done      = 1'b0;
          @(negedge clk);
        end
        mmu_res_valid = 1'b1;
        mmu_res_out   = 18'(r);
        mmu_done      = (!done_sep && i == nres - 1);
        if (i < 32) begin
          if (lay % 2 == 0) m1[i] = rq(r);
          else              m0[i] = rq(r);
        end
        @(negedge clk);
      end
      mmu_res_valid = 1'b0;
      if (done_sep) begin
        chk("sel_hold_before_done", {30'd0, mmu_layer_sel}, lay);
        mmu_done = 1'b1;
        @(negedge clk);
      end
      mmu_done = 1'b0;
    end else begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      mmu_res_valid = 1'b1;
      mmu_res_out   = 18'(l3_val);
      @(negedge clk);
      mmu_res_valid = 1'b0;
      chk("l3_capture", {14'd0, result_out}, l3_val);
      chk("rv_not_yet", {31'd0, result_valid}, 32'd0);
      chk("busy_finish", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("rv_pulse", {31'd0, result_valid}, 32'd1);
      chk("busy_fall", {31'd0, busy}, 32'd0);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("rv_single", {31'd0, result_valid}, 32'd0);
      chk("result_hold", {14'd0, result_out}, l3_val);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    mmu_res_valid = 1'b0;
    mmu_res_out = '0;
    mmu_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", {31'd0, mmu_start}, 32'd0);
    chk("rst_act_valid", {31'd0, mmu_act_valid}, 32'd0);
    chk("rst_act_in", {24'd0, mmu_act_in}, 32'd0);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_result_out", {14'd0, result_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_layer_sel", {30'd0, mmu_layer_sel}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    chk("busy_after_rst", {31'd0, busy}, 32'd0);

    // stray MMU result while idle
    mmu_res_valid = 1'b1;
    mmu_done = 1'b1;
    mmu_res_out = 18'h3FFFF;
    @(negedge clk);
    mmu_res_valid = 1'b0;
    mmu_done = 1'b0;
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_in_ready", {31'd0, in_ready}, 32'd1);
    chk("stray_result_valid", {31'd0, result_valid}, 32'd0);

    // run 1: gapped load 1..4, fixed requantise cases, stray in_valid in L1
    feat[0] = 8'd1; feat[1] = 8'd2; feat[2] = 8'd3; feat[3] = 8'd4;
    load4(1'b1);
    fixed_q.push_back(32'h50);
    fixed_q.push_back(32'h3FFF);
    fixed_q.push_back(0);
    run_layer(0, 32, 1'b0, 1'b0, -1);
    run_layer(1, 32, 1'b0, 1'b1, -1);
    run_layer(2, 32, 1'b0, 1'b0, -1);
    l3_val = 32'h00123;
    run_layer(3, 1, 1'b0, 1'b0, -1);

    // run 2: random features, 33 results in L1 with done on its own cycle
    for (int i = 0; i < 4; i++) feat[i] = 8'($urandom_range(0, 255));
    load4(1'b0);
    run_layer(0, 32, 1'b0, 1'b0, -1);
    run_layer(1, 33, 1'b1, 1'b0, -1);
    run_layer(2, 32, 1'b0, 1'b0, -1);
    l3_val = int'($urandom_range(0, 32'h3FFFF));
    run_layer(3, 1, 1'b0, 1'b0, -1);

    // run 3: reset during layer-2 stream
    for (int i = 0; i < 4; i++) feat[i] = 8'($urandom_range(0, 255));
    load4(1'b0);
    run_layer(0, 32, 1'b0, 1'b0, -1);
    run_layer(1, 32, 1'b0, 1'b0, -1);
    run_layer(2, 32, 1'b0, 1'b0, 7);

    // run 4: fresh full run after the abort
    for (int i = 0; i < 4; i++) feat[i] = 8'($urandom_range(0, 255));
    load4(1'b1);
    run_layer(0, 32, 1'b0, 1'b0, -1);
    run_layer(1, 32, 1'b0, 1'b0, -1);
    run_layer(2, 32, 1'b0, 1'b0, -1);
    l3_val = int'($urandom_range(0, 32'h3FFFF));
    run_layer(3, 1, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t01_ai_layer_seq.md
T01_AI_LAYER_SEQ -- requirements
Module: t01_ai_layer_seq

Interface
REQ-001 SHALL have parameter SHIFT, default 4: right-shift applied when requantising 18-bit layer results to 8-bit activations.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: an input feature is offered.
REQ-005 SHALL have port in_data, input, 8 bits: signed input feature.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a feature this cycle.
REQ-007 SHALL have port mmu_start, output, 1 bit: one-cycle start pulse to the MMU.
REQ-008 SHALL have port mmu_layer_sel, output, 2 bits: layer index driven to the MMU.
REQ-009 SHALL have port mmu_act_valid, output, 1 bit: an activation is presented to the MMU.
REQ-010 SHALL have port mmu_act_in, output, 8 bits: signed activation to the MMU.
REQ-011 SHALL have port mmu_res_valid, input, 1 bit: an MMU result is present.
REQ-012 SHALL have port mmu_res_out, input, 18 bits: MMU result, already ReLU'd and therefore non-negative.
REQ-013 SHALL have port mmu_done, input, 1 bit: the MMU's last result of the current layer.
REQ-014 SHALL have port result_valid, output, 1 bit: one-cycle pulse marking the final network output.
REQ-015 SHALL have port result_out, output, 18 bits: final network output.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, START, STREAM, COLLECT, FINISH, with a 2-bit layer counter L (0..3).
REQ-018 SHALL contain two activation banks, B0 and B1, each 32 x 8 bits.
REQ-019 IDLE: SHALL drive in_ready=1; on in_valid, SHALL write in_data to B0[0], set the load index to 1, and go to LOAD.
REQ-020 LOAD: SHALL keep in_ready=1 and write each accepted feature to B0[idx]; after the 4th accepted feature SHALL clear L to 0 and go to START; in_valid=0 cycles SHALL stall with no write.
REQ-021 in_ready SHALL be 0 in every state except IDLE and LOAD; in_valid while in_ready=0 SHALL be ignored.
REQ-022 mmu_layer_sel SHALL equal L at all times.
REQ-023 START: SHALL assert mmu_start for exactly one cycle and clear the stream index, then go to STREAM.
REQ-024 STREAM: SHALL assert mmu_act_valid for exactly N consecutive cycles (N=4 when L=0, otherwise 32), presenting read-bank entries in index order 0..N-1, then go to COLLECT.
REQ-025 Bank mapping SHALL be: L0 reads B0, writes B1; L1 reads B1, writes B0; L2 reads B0, writes B1; L3 reads B1.
REQ-026 mmu_act_in SHALL be 0 whenever mmu_act_valid=0.
REQ-027 COLLECT, L<3: each mmu_res_valid SHALL write q = min(mmu_res_out >> SHIFT, 127) to write-bank[cidx] and increment cidx.
REQ-028 Writes with cidx >= 32 SHALL be dropped.
REQ-029 COLLECT, L<3, on mmu_done: SHALL increment L and go to START; the result arriving in the same cycle as mmu_done SHALL still be written.
REQ-030 COLLECT, L=3, on mmu_res_valid: SHALL register mmu_res_out unmodified into result_out and go to FINISH.
REQ-031 FINISH: SHALL pulse result_valid=1 for exactly one cycle, then go to IDLE.
REQ-032 result_out SHALL hold its value until the next L=3 capture.
REQ-033 mmu_res_valid and mmu_done outside COLLECT SHALL be ignored.
REQ-034 A new input set SHALL be accepted only after FINISH; back-to-back runs SHALL reuse the banks without clearing them.
REQ-035 All outputs SHALL be registered; result_valid SHALL rise one cycle after the L=3 result is captured.

Reset
REQ-036 While rst=1 at a clock edge: SHALL set state=IDLE, L=0, and clear all indices.
REQ-037 While rst=1 at a clock edge: SHALL set mmu_start=0, mmu_act_valid=0, mmu_act_in=0, result_valid=0, result_out=0, busy=0; in_ready SHALL become 1 on the first cycle after reset deasserts.
REQ-038 Bank contents SHALL NOT be reset.
REQ-039 Reset asserted mid-run (any state) SHALL abort the run at that edge with no result_valid pulse.

Verification
REQ-040 Load: in_data 1,2,3,4 with in_valid gapped on every other cycle -> B0[0..3]=1,2,3,4; exactly one mmu_start, with layer_sel=0; then 4 act_valid cycles carrying 1,2,3,4.
REQ-041 Requantise, SHIFT=4: mmu_res_out 0x00050 -> 5; 0x03FFF -> 127; 0 -> 0; the values then reappear in that order on mmu_act_in during layer 1.
REQ-042 Full run against an MMU model (32 results per layer, 1 at L3, L3 value 0x00123) -> layer_sel sequence 0,1,2,3; act_valid cycle counts 4,32,32,32; result_out=0x00123; a single result_valid pulse; busy falls with the return to IDLE.
REQ-043 Stray input: mmu_res_valid pulsed while in IDLE, and in_valid asserted during STREAM -> no bank change, no extra input accepted, no state change.
REQ-044 Abort: rst asserted during layer-2 STREAM -> next cycle all outputs at reset values; a fresh 4-feature load then completes a full run.
REQ-045 Overflow: 33 mmu_res_valid pulses before mmu_done in L1 -> entries 0..31 written, the 33rd dropped, L advances to 2 on mmu_done.
